// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_queue
//  Description : Fetch-to-decode instruction queue. DEPTH-entry FIFO holding
//                {instruction, PC+4} pairs with valid/ready handshakes on both
//                sides, a flush that discards every queued word, and
//                pre-split instruction fields on the head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_queue #(
    parameter int                   DATA_W = 16,
    parameter int                   DEPTH  = 2,
    parameter logic [DATA_W-1:0]    NOP    = '0
) (
    input  logic                            clock,
    input  logic                            reset_n,
    // fetch side
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W-1:0]               in_instr,
    input  logic [DATA_W-1:0]               in_pc4,
    // branch-taken discard
    input  logic                            flush,
    // decode side
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_instr,
    output logic [DATA_W-1:0]               out_pc4,
    output logic [3:0]                      out_opcode,
    output logic [3:0]                      out_rd,
    output logic [3:0]                      out_rs,
    output logic [3:0]                      out_rt,
    output logic [DATA_W-1:0]               out_imm,
    output logic [$clog2(DEPTH):0]          count
);

    // Pointer and occupancy widths; the occupancy needs one extra bit so
    // that a full queue (count == DEPTH) is representable.
    localparam int                  c_PTR_W    = $clog2(DEPTH);
    localparam int                  c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL = c_CNT_W'(DEPTH);

    // Entry storage; contents are meaningless until written, so no reset.
    logic [DATA_W-1:0]  r_instr_mem [DEPTH];
    logic [DATA_W-1:0]  r_pc4_mem   [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;
    logic [DATA_W-1:0]  w_head_instr;
    logic [DATA_W-1:0]  w_head_pc4;

    // Handshake qualifiers. A full queue never accepts a word, even when the
    // head is popped in the same cycle: no bypass path from pop to push.
    assign w_in_ready  = (r_count < c_CNT_FULL);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid  & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    // Pointer and occupancy bookkeeping. Flush wins over any same-cycle
    // push or pop; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Capture accepted words at the write pointer; a word arriving together
    // with a flush is dropped.
    always_ff @(posedge clock) begin
        if (w_push && !flush) begin
            r_instr_mem[r_wr_ptr] <= in_instr;
            r_pc4_mem[r_wr_ptr]   <= in_pc4;
        end
    end

    // Head selection: the stored entry when valid, otherwise a NOP with a
    // zero PC+4 so that decode sees a harmless instruction while idle.
    always_comb begin
        w_head_instr = NOP;
        w_head_pc4   = '0;
        if (w_out_valid) begin
            w_head_instr = r_instr_mem[r_rd_ptr];
            w_head_pc4   = r_pc4_mem[r_rd_ptr];
        end
    end

    // Pre-split fields are plain slices of the head instruction; the
    // immediate is the low byte sign-extended to the full data width.
    always_comb begin
        out_opcode = w_head_instr[15:12];
        out_rd     = w_head_instr[11:8];
        out_rs     = w_head_instr[7:4];
        out_rt     = w_head_instr[3:0];
        out_imm    = {{(DATA_W-8){w_head_instr[7]}}, w_head_instr[7:0]};
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_instr = w_head_instr;
    assign out_pc4   = w_head_pc4;
    assign count     = r_count;

endmodule
`default_nettype wire
